// File: rtl/resp_byte_packer_if.sv
// Request/FIFO-push bundle for resp_byte_packer; master is the controller/FIFO side,
// slave is the packer.
interface resp_byte_packer_if #(
    parameter int DATA_WIDTH = 8
);
    // Request handshake: a response transfers on a rising edge where REQ_VLD and REQ_RDY
    // are both high; REQ_TYPE/REQ_DATA must be stable while REQ_VLD waits for REQ_RDY.
    // FIFO side: a byte is written on every edge where TX_D_VLD is high.
    logic                    REQ_VLD;
    logic                    REQ_TYPE;
    logic [2*DATA_WIDTH-1:0] REQ_DATA;
    logic                    REQ_RDY;
    logic                    FIFO_FULL;
    logic                    TX_D_VLD;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    BUSY;
    logic [7:0]              TX_CNT;

    modport master (
        output REQ_VLD, REQ_TYPE, REQ_DATA, FIFO_FULL,
        input  REQ_RDY, TX_D_VLD, TX_P_DATA, BUSY, TX_CNT
    );

    modport slave (
        input  REQ_VLD, REQ_TYPE, REQ_DATA, FIFO_FULL,
        output REQ_RDY, TX_D_VLD, TX_P_DATA, BUSY, TX_CNT
    );
endinterface

// File: rtl/resp_byte_packer.sv
// Serialises byte/word responses into the TX FIFO, low byte first, with FIFO_FULL backpressure.
// Define RESP_CHECKSUM_EN to append an XOR checksum byte after each response's payload.
module resp_byte_packer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    resp_byte_packer_if.slave    bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_LO  = 2'd1,
        SEND_HI  = 2'd2
`ifdef RESP_CHECKSUM_EN
        ,
        SEND_CHK = 2'd3
`endif
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  type_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [DATA_WIDTH-1:0] hi_q;
`ifdef RESP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_q;
`endif
    logic [7:0]            cnt_q;

    logic                  push;
    logic                  last;
    logic                  rdy;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_mux;

    // Reset is gated into the strobes so nothing is pushed or accepted while RST is high.
    always_comb begin
        push = !RST && (state != IDLE) && !bus.FIFO_FULL;

        last = 1'b0;
        case (state)
`ifdef RESP_CHECKSUM_EN
            SEND_CHK: last = 1'b1;
`else
            SEND_LO:  last = !type_q;
            SEND_HI:  last = 1'b1;
`endif
            default:  last = 1'b0;
        endcase

        rdy    = !RST && ((state == IDLE) || (last && !bus.FIFO_FULL));
        accept = bus.REQ_VLD && rdy;

        state_nxt = state;
        if (state == IDLE) begin
            if (accept) state_nxt = SEND_LO;
        end else if (push) begin
            if (last) begin
                state_nxt = accept ? SEND_LO : IDLE;
            end else begin
                case (state)
`ifdef RESP_CHECKSUM_EN
                    SEND_LO: state_nxt = type_q ? SEND_HI : SEND_CHK;
                    SEND_HI: state_nxt = SEND_CHK;
`else
                    SEND_LO: state_nxt = SEND_HI;
`endif
                    default: state_nxt = state;
                endcase
            end
        end

        data_mux = '0;
        case (state)
            SEND_LO:  data_mux = lo_q;
            SEND_HI:  data_mux = hi_q;
`ifdef RESP_CHECKSUM_EN
            SEND_CHK: data_mux = chk_q;
`endif
            default:  data_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Payload is captured at acceptance so later request-bus changes cannot disturb it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            type_q <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
`ifdef RESP_CHECKSUM_EN
            chk_q  <= '0;
`endif
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                type_q <= bus.REQ_TYPE;
                lo_q   <= bus.REQ_DATA[DATA_WIDTH-1:0];
                hi_q   <= bus.REQ_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef RESP_CHECKSUM_EN
                chk_q  <= bus.REQ_TYPE
                          ? (bus.REQ_DATA[DATA_WIDTH-1:0] ^ bus.REQ_DATA[2*DATA_WIDTH-1:DATA_WIDTH])
                          : bus.REQ_DATA[DATA_WIDTH-1:0];
`endif
            end
            if (push) cnt_q <= cnt_q + 8'd1;
        end
    end

    assign bus.REQ_RDY   = rdy;
    assign bus.TX_D_VLD  = push;
    assign bus.TX_P_DATA = data_mux;
    assign bus.BUSY      = (state != IDLE);
    assign bus.TX_CNT    = cnt_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_resp_byte_packer.sv
// Bench for resp_byte_packer: byte-queue model checked every cycle plus directed literal checks.
// Builds with or without RESP_CHECKSUM_EN.
module tb_resp_byte_packer;

`ifdef RESP_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    resp_byte_packer_if #(.DATA_WIDTH(8)) bus ();

    resp_byte_packer #(.DATA_WIDTH(8)) dut (
        .CLK       (clk),
        .RST       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    bit         model_on = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt;
    logic [7:0] log_q[$];
    int         logc_q[$];
    logic [7:0] want_q[$];

    logic       exp_busy, exp_vld, exp_rdy;
    logic [7:0] exp_data;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Response-level model: remaining bytes of the response in flight live in exp_q.
    always @(negedge clk) begin
        if (model_on) begin
            exp_busy = (exp_q.size() != 0);
            exp_vld  = !rst && exp_busy && !bus.FIFO_FULL;
            exp_rdy  = !rst && (!exp_busy || (exp_q.size() == 1 && !bus.FIFO_FULL));
            exp_data = exp_busy ? exp_q[0] : 8'h00;
            chk("busy",    16'(bus.BUSY),      16'(exp_busy));
            chk("tx_vld",  16'(bus.TX_D_VLD),  16'(exp_vld));
            chk("req_rdy", 16'(bus.REQ_RDY),   16'(exp_rdy));
            chk("tx_data", 16'(bus.TX_P_DATA), 16'(exp_data));
            chk("tx_cnt",  16'(bus.TX_CNT),    16'(exp_cnt));
            if (bus.TX_D_VLD === 1'b1) begin
                log_q.push_back(bus.TX_P_DATA);
                logc_q.push_back(cyc);
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_cnt  = 8'h00;
            model_on = 1'b1;
        end else if (model_on) begin
            if (exp_vld) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 8'd1;
            end
            if (bus.REQ_VLD && exp_rdy) begin
                exp_q.push_back(bus.REQ_DATA[7:0]);
                if (bus.REQ_TYPE) exp_q.push_back(bus.REQ_DATA[15:8]);
                if (CHK_EN)
                    exp_q.push_back(bus.REQ_TYPE ? (bus.REQ_DATA[7:0] ^ bus.REQ_DATA[15:8])
                                                 : bus.REQ_DATA[7:0]);
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic t, input logic [15:0] d);
        @(posedge clk);
        #1;
        bus.REQ_VLD  = 1'b1;
        bus.REQ_TYPE = t;
        bus.REQ_DATA = d;
    endtask

    // Returns at posedge+1 just after the edge that accepted the pending request.
    task automatic wait_accept(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.REQ_RDY !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk(name, 16'(n < 50), 16'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_q.delete();
        logc_q.delete();
    endtask

    task automatic check_log(input string name);
        chk({name, "_len"}, 16'(log_q.size()), 16'(want_q.size()));
        for (int i = 0; i < want_q.size() && i < log_q.size(); i++)
            chk({name, "_byte"}, 16'(log_q[i]), 16'(want_q[i]));
    endtask

    logic [7:0]  full_pat = 8'b0110_0101;
    logic        mix_t[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] mix_d[6] = '{16'hC001, 16'h0077, 16'hFF00, 16'h8421, 16'h00AA, 16'h0001};

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b1;
        bus.REQ_VLD   = 1'b0;
        bus.REQ_TYPE  = 1'b0;
        bus.REQ_DATA  = 16'h0000;
        bus.FIFO_FULL = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        repeat (5) begin
            @(negedge clk);
            chk("idle_rdy",  16'(bus.REQ_RDY),   16'd1);
            chk("idle_vld",  16'(bus.TX_D_VLD),  16'd0);
            chk("idle_data", 16'(bus.TX_P_DATA), 16'd0);
            chk("idle_busy", 16'(bus.BUSY),      16'd0);
            chk("idle_cnt",  16'(bus.TX_CNT),    16'd0);
        end

        // Word response BEEF; request bus scrambled after acceptance
        clear_log();
        drive(1'b1, 16'hBEEF);
        wait_accept("word_acc");
        bus.REQ_VLD  = 1'b0;
        bus.REQ_DATA = 16'h0000;
        @(negedge clk);
        chk("word_lo_vld", 16'(bus.TX_D_VLD), 16'd1);
        chk("word_lo",     16'(bus.TX_P_DATA), 16'h00EF);
        @(negedge clk);
        chk("word_hi",     16'(bus.TX_P_DATA), 16'h00BE);
        repeat (3) @(negedge clk);
        chk("word_busy",   16'(bus.BUSY), 16'd0);
        chk("word_cnt",    16'(bus.TX_CNT), CHK_EN ? 16'd3 : 16'd2);
        want_q = '{8'hEF, 8'hBE};
        if (CHK_EN) want_q.push_back(8'h51);
        check_log("word");

        // Back-to-back byte responses with REQ_VLD held
        clear_log();
        drive(1'b0, 16'h003C);
        wait_accept("b2b_acc0");
        bus.REQ_DATA = 16'h005A;
        wait_accept("b2b_acc1");
        bus.REQ_VLD = 1'b0;
        repeat (4) @(negedge clk);
        want_q = CHK_EN ? '{8'h3C, 8'h3C, 8'h5A, 8'h5A} : '{8'h3C, 8'h5A};
        check_log("b2b");
        if (logc_q.size() > 0)
            chk("b2b_gap", 16'(logc_q[logc_q.size()-1] - logc_q[0]), 16'(logc_q.size() - 1));

        // Backpressure mid-word
        clear_log();
        drive(1'b1, 16'h1234);
        wait_accept("bp_acc");
        bus.REQ_VLD = 1'b0;
        @(negedge clk);
        chk("bp_lo", 16'(bus.TX_P_DATA), 16'h0034);
        @(posedge clk);
        #1 bus.FIFO_FULL = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_vld",  16'(bus.TX_D_VLD),  16'd0);
            chk("bp_stall_data", 16'(bus.TX_P_DATA), 16'h0012);
        end
        @(posedge clk);
        #1 bus.FIFO_FULL = 1'b0;
        @(negedge clk);
        chk("bp_hi_vld", 16'(bus.TX_D_VLD),  16'd1);
        chk("bp_hi",     16'(bus.TX_P_DATA), 16'h0012);
        repeat (3) @(negedge clk);
        want_q = '{8'h34, 8'h12};
        if (CHK_EN) want_q.push_back(8'h26);
        check_log("bp");

        // Mixed responses under a repeating FIFO_FULL pattern (model-checked)
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    bus.REQ_TYPE = mix_t[k];
                    bus.REQ_DATA = mix_d[k];
                    bus.REQ_VLD  = 1'b1;
                    wait_accept("mix_acc");
                end
                bus.REQ_VLD = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1 bus.FIFO_FULL = full_pat[c % 8];
                end
                bus.FIFO_FULL = 1'b0;
            end
        join
        repeat (6) @(negedge clk);

        // Reset during SEND_HI of A55A
        clear_log();
        drive(1'b1, 16'hA55A);
        wait_accept("rst_acc");
        bus.REQ_VLD = 1'b0;
        @(negedge clk);
        chk("rst_lo", 16'(bus.TX_P_DATA), 16'h005A);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_no_push", 16'(bus.TX_D_VLD), 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 16'(bus.BUSY),   16'd0);
        chk("rst_cnt",  16'(bus.TX_CNT), 16'd0);
        want_q = '{8'h5A};
        check_log("rst");

        // Counter wrap over 256 byte responses
        clear_log();
        drive(1'b0, 16'h0000);
        for (int i = 0; i < 256; i++) begin
            bus.REQ_DATA = 16'(i);
            wait_accept("wrap_acc");
        end
        bus.REQ_VLD = 1'b0;
        repeat (4) @(negedge clk);
        chk("wrap_cnt",  16'(bus.TX_CNT), 16'd0);
        chk("wrap_len",  16'(log_q.size()), CHK_EN ? 16'd512 : 16'd256);
        if (log_q.size() > 0)
            chk("wrap_last", 16'(log_q[log_q.size()-1]), 16'h00FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/resp_byte_packer.md
# resp_byte_packer

Response serializer between the system controller's result path and the write side of the TX async FIFO, in the REF_CLK domain. It accepts one response per handshake, either an 8-bit register-file read value or a 16-bit ALU result. It emits that response as a sequence of bytes into the FIFO, honouring FIFO_FULL backpressure, and optionally appends an XOR checksum byte. It keeps the FIFO push protocol and byte ordering in one place, so the controller issues one request per result.

## Interface
- DATA_WIDTH, 8, byte width pushed into the FIFO; responses are up to 2*DATA_WIDTH bits.
- CLK  in  1  REF_CLK-domain clock (mux-selected scan clock in test mode).
- RST  in  1  synchronous, active-high reset, sampled on rising CLK.
- REQ_VLD  in  1  response request valid.
- REQ_TYPE  in  1  0 = byte response (REQ_DATA[7:0] only), 1 = word response (all 16 bits).
- REQ_DATA  in  2*DATA_WIDTH  response payload.
- REQ_RDY  out  1  request accepted when REQ_VLD & REQ_RDY on a rising edge.
- FIFO_FULL  in  1  FIFO write-side full flag.
- TX_D_VLD  out  1  FIFO write strobe (W_INC).
- TX_P_DATA  out  DATA_WIDTH  FIFO write data.
- BUSY  out  1  high while any byte of the current response is still unsent.
- TX_CNT  out  8  count of bytes pushed since reset; wraps 255 -> 0.

## Operation
- States:
  - IDLE
  - SEND_LO
  - SEND_HI
  - SEND_CHK (present only with the macro)
- Payload capture: on acceptance, REQ_DATA and REQ_TYPE are captured into internal registers. Later changes on the request inputs do not affect the response in flight.
- Byte order: low byte first, then high byte (word only), then checksum (if enabled).
- Push rule: TX_D_VLD = (state != IDLE) & !FIFO_FULL, a combinational gate on the registered state.
  - A byte transfers in every cycle where TX_D_VLD = 1.
  - When FIFO_FULL = 1, the state and TX_P_DATA hold.
- TX_P_DATA is a mux of the captured registers selected by state. It is 0 in IDLE.
- State transitions on a transfer:
  - SEND_LO -> SEND_HI if word.
  - SEND_LO -> SEND_CHK if byte and macro enabled.
  - SEND_LO -> final otherwise.
  - SEND_HI -> SEND_CHK if macro enabled, else final.
  - SEND_CHK -> final.
- Final-byte exit: when the final byte transfers, the next state is SEND_LO if a new request is accepted in the same cycle, else IDLE.
- REQ_RDY = (state == IDLE) | (final-byte state & !FIFO_FULL). This allows back-to-back responses with no bubble.
- BUSY = (state != IDLE).
- TX_CNT increments by 1 on every transfer, modulo 256.
- RST: state goes to IDLE, and captured data, checksum and TX_CNT clear to 0.
  - A response in flight is discarded with no further pushes.
  - A request presented during RST is not accepted.

## Timing
- Acceptance at edge N puts SEND_LO in the cycle after N. With FIFO_FULL = 0, TX_D_VLD is high in that cycle.
- Latency, request accepted to first push: 1 cycle.
- Push count per response without stall:
  - byte: 1 cycle
  - word: 2 cycles
  - +1 cycle each with the checksum enabled.
- Sustained throughput: 1 byte/cycle. Each FIFO_FULL cycle adds exactly one stall cycle.
- Simultaneous events:
  - FIFO_FULL rising in the final-byte cycle deasserts REQ_RDY in that same cycle. The request waits and is not lost.
  - RST has priority over all other inputs.
- Reset values: REQ_RDY=1, TX_D_VLD=0, TX_P_DATA=0, BUSY=0, TX_CNT=0.

## Configuration
- RESP_CHECKSUM_EN defined:
  - SEND_CHK is compiled in.
  - After the payload, one extra byte is pushed: the XOR of all payload bytes of that response.
  - Byte response: checksum = low byte. Word response: checksum = lo ^ hi.
- RESP_CHECKSUM_EN undefined: SEND_CHK and the checksum register are absent, and every response ends at its last payload byte.

## Test plan
- Reset then idle, macro off: RST=1 for 2 cycles, then 5 cycles with REQ_VLD=0 -> REQ_RDY=1, TX_D_VLD=0, TX_P_DATA=0, BUSY=0, TX_CNT=0 throughout.
- Word response, macro off: REQ_TYPE=1, REQ_DATA=16'hBEEF, FIFO_FULL=0 -> pushes 8'hEF then 8'hBE on consecutive cycles, TX_CNT=2, and BUSY drops after the second push.
- Back-to-back byte responses, macro on: 8'h3C then 8'h5A held valid -> pushes 3C, 3C, 5A, 5A on consecutive cycles with no idle cycle between responses.
- Backpressure mid-word: REQ_DATA=16'h1234 with FIFO_FULL=1 for 3 cycles after the low-byte push -> TX_D_VLD=0 and TX_P_DATA=8'h12 holding for those cycles, then 8'h12 pushes once, and the total push count is exactly 2.
- Reset mid-operation: RST asserted during SEND_HI of 16'hA55A -> no 8'hA5 push, IDLE the next cycle, TX_CNT=0.
- Counter wrap: 256 byte responses -> TX_CNT returns to 0 after the 256th push.
